// File: rtl/mux_rr_arbiter_4to1.sv
// mux_rr_arbiter_4to1
//   Round-robin arbiter and select sequencer for one shared 4-to-1 data mux.
//   Grants one of four level-sensitive requesters. A grant is held for at most
//   MAX_HOLD consecutive cycles. The selected requester data is registered to f.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous active-high reset
//   req      : request lines, bit i belongs to requester i
//   d0..d3   : requester data inputs (W bits each)
//   gnt      : registered one-hot grant (all-zero when idle)
//   sel      : registered binary index of the grantee (mux select)
//   f        : registered mux output
//   f_valid  : f holds data sampled from an active grantee
module mux_rr_arbiter_4to1 #(
  parameter int W        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic [W-1:0] f,
  output logic         f_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q,   ptr_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic [3:0]   gnt_q,   gnt_d;
  logic [1:0]   sel_q,   sel_d;
  logic [W-1:0] f_q,     f_d;
  logic         f_valid_q, f_valid_d;

  // Returns {found, index}: first requester at or after ptr, wrapping mod 4.
  // Scanning from the far end and overwriting leaves the nearest one.
  function automatic logic [2:0] pick(input logic [1:0] ptr, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned k = 4; k > 0; k--) begin
      idx = ptr + 2'(k - 1);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  logic [W-1:0] d_sel;
  logic [2:0]   win_idle;
  logic [2:0]   win_rel;
  logic [1:0]   ptr_next;
  logic         release_c;

  always_comb begin
    d_sel = d0;
    case (sel_q)
      2'd0: d_sel = d0;
      2'd1: d_sel = d1;
      2'd2: d_sel = d2;
      2'd3: d_sel = d3;
      default: d_sel = d0;
    endcase
  end

  assign ptr_next  = sel_q + 2'd1;
  assign win_idle  = pick(ptr_q, req);
  assign win_rel   = pick(ptr_next, req);
  assign release_c = !req[sel_q] || (cnt_q == 4'(MAX_HOLD));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      f_q       <= '0;
      f_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    f_d       = f_q;
    f_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_idle[2]) begin
          gnt_d   = onehot(win_idle[1:0]);
          sel_d   = win_idle[1:0];
          cnt_d   = 4'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (req[sel_q]) begin
          f_d       = d_sel;
          f_valid_d = 1'b1;
        end
        if (release_c) begin
          // The outgoing grantee drops to lowest priority; the handoff to the
          // next winner happens on this same edge, so there is no idle bubble.
          ptr_d = ptr_next;
          if (win_rel[2]) begin
            gnt_d = onehot(win_rel[1:0]);
            sel_d = win_rel[1:0];
            cnt_d = 4'd1;
          end else begin
            gnt_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt     = gnt_q;
    sel     = sel_q;
    f       = f_q;
    f_valid = f_valid_q;
  end

endmodule

// File: tb/tb_mux_rr_arbiter_4to1.sv
module tb_mux_rr_arbiter_4to1;

  localparam int W = 8;
  localparam int MAXH = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [W-1:0] d [4];
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [W-1:0] f;
  logic         f_valid;

  int n_tests = 0;
  int n_fail  = 0;

  mux_rr_arbiter_4to1 #(.W(W), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .gnt(gnt), .sel(sel), .f(f), .f_valid(f_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the mux (-1 = nobody), rotation pointer,
  // how many cycles the owner has held it, last select, and the data output.
  int       m_own, m_ptr, m_held, m_sel;
  logic [W-1:0] m_f;
  bit       m_fv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_from(input int start, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_f = '0; m_fv = 0;
  endtask

  task automatic model_edge();
    int w;
    m_fv = 0;
    if (m_own < 0) begin
      w = first_from(m_ptr, req);
      if (w >= 0) begin m_own = w; m_sel = w; m_held = 1; end
    end else begin
      if (req[m_own]) begin m_f = d[m_own]; m_fv = 1; end
      if (!req[m_own] || m_held == MAXH) begin
        m_ptr = (m_own + 1) % 4;
        w = first_from(m_ptr, req);
        if (w >= 0) begin m_own = w; m_sel = w; m_held = 1; end
        else m_own = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
  endfunction

  // One clock edge: advance the model with the inputs present before the edge,
  // then compare DUT outputs 1 ns after the edge.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".gnt"}, 32'(gnt), 32'(m_gnt()));
    check({tag, ".sel"}, 32'(sel), 32'(m_sel));
    check({tag, ".f"}, 32'(f), 32'(m_f));
    check({tag, ".fv"}, 32'(f_valid), 32'(m_fv));
    check({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear without an edge.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".rgnt"}, 32'(gnt), 32'd0);
    check({tag, ".rsel"}, 32'(sel), 32'd0);
    check({tag, ".rf"}, 32'(f), 32'd0);
    check({tag, ".rfv"}, 32'(f_valid), 32'd0);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [3:0] r;
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 * (i + 1));
    model_reset();
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset.gnt", 32'(gnt), 32'd0);
    check("reset.fv", 32'(f_valid), 32'd0);

    // Reset mid-grant
    req = 4'b0001;
    step("rmg0");
    step("rmg1");
    pulse_reset("rmg");
    req = 4'b0100;
    step("rmg2");
    check("rmg.gnt_abs", 32'(gnt), 32'b0100);
    check("rmg.sel_abs", 32'(sel), 32'd2);
    req = 4'b0000;
    step("rmg3");
    pulse_reset("rst1");

    // Single requester
    d[0] = 8'hA5;
    req = 4'b0001;
    step("single0");
    check("single.gnt1", 32'(gnt), 32'b0001);
    for (int i = 0; i < 10; i++) begin
      step("single");
      check("single.hold", 32'(gnt), 32'b0001);
      check("single.f", 32'(f), 32'hA5);
    end
    req = 4'b0000;
    step("single_drop");
    check("single.drop_gnt", 32'(gnt), 32'd0);
    check("single.drop_f", 32'(f), 32'hA5);
    check("single.drop_fv", 32'(f_valid), 32'd0);
    pulse_reset("rst2");

    // Full contention: each requester for exactly MAX_HOLD cycles, in order
    req = 4'b1111;
    for (int c = 0; c < 5 * MAXH; c++) begin
      step("full");
      check("full.seq", 32'(gnt), 32'(1 << ((c / MAXH) % 4)));
    end
    pulse_reset("rst3");

    // Early release with handoff
    req = 4'b0101;
    step("early0");
    check("early.g0", 32'(gnt), 32'b0001);
    step("early1");
    req = 4'b0100;
    step("early2");
    check("early.handoff", 32'(gnt), 32'b0100);
    check("early.fv0", 32'(f_valid), 32'd0);
    step("early3");
    check("early.fv1", 32'(f_valid), 32'd1);
    check("early.fd2", 32'(f), 32'(d[2]));
    pulse_reset("rst4");

    // Wrap-around: after releasing 2, pointer is 3 so requester 0 wins over 2
    req = 4'b0100;
    step("wrap0");
    step("wrap1");
    req = 4'b0000;
    step("wrap2");
    req = 4'b0101;
    step("wrap3");
    check("wrap.gnt", 32'(gnt), 32'b0001);

    // All requests drop, then the same index re-requests
    req = 4'b0000;
    step("drop0");
    check("drop.idle", 32'(gnt), 32'd0);
    req = 4'b0001;
    step("drop1");
    check("drop.regrant", 32'(gnt), 32'b0001);

    // Randomized traffic with occasional resets
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      req = r;
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset("rnd_rst");
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_rr_arbiter_4to1.md
# mux_rr_arbiter_4to1

Round-robin arbiter and select sequencer that shares one 4-to-1 data mux among four requesters. Each cycle it decides which requester owns the mux, drives the one-hot grant and the binary select, and registers the selected data to the output. Grant hold time is bounded so that no requester can starve the others. It sits in front of the shared mux datapath and replaces a free-running or externally driven select line.

## Interface
- W, default 8: data width of each requester input and of the output.
- MAX_HOLD, default 4: maximum consecutive grant cycles per requester. Legal range is 1..15.
- clk  in  1  the single clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  request lines. Bit i belongs to requester i and is level-sensitive.
- d0, d1, d2, d3  in  W each  requester data inputs.
- gnt  out  4  one-hot grant, or all-zero. Registered.
- sel  out  2  binary index of the current grantee. Drives the mux select. Registered.
- f  out  W  registered mux output.
- f_valid  out  1  f holds data sampled from an active grantee.

## Operation
- State is one of IDLE or GRANT. Internal registers:
  - ptr (2 bits): the highest-priority index.
  - cnt (4 bits): the hold counter.
- Priority order for a grant decision is ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first index with req high wins.
- IDLE:
  - gnt=0.
  - If any req bit is high at an edge: gnt ← one-hot(winner), sel ← winner, cnt ← 1, state ← GRANT.
- GRANT, at each edge, with s = sel:
  - Data capture: f ← d[s] and f_valid ← req[s]. If req[s] is low, f holds its old value and f_valid ← 0.
  - Release occurs if req[s]=0 or cnt==MAX_HOLD.
  - On release:
    - ptr ← s+1 mod 4.
    - The winner is picked from the current req using the new ptr.
    - If there is a winner: gnt/sel ← winner and cnt ← 1, in the same edge with no idle bubble.
    - If there is no winner: gnt ← 0 and state ← IDLE.
  - Otherwise cnt ← cnt+1.
- The current grantee has lowest priority after release. It is re-granted only if no other requester is high. In that case gnt stays constant and cnt restarts at 1.
- IDLE edge: f holds its value and f_valid ← 0.
- gnt is never multi-hot. sel changes only when gnt changes to a new one-hot value. sel holds its value in IDLE.

## Timing
- Reset values, applied asynchronously while rst is high:
  - Outputs: gnt=0, sel=0, f=0, f_valid=0.
  - Internal: ptr=0, cnt=0, state=IDLE.
- Reset mid-grant clears everything immediately. The first decision after rst falls uses ptr=0.
- Request-to-grant latency from IDLE: 1 edge. A req first high before edge k gives gnt at edge k.
- Grant-to-data latency: the first f_valid=1 appears at the edge after gnt rises (edge k+1). f carries d[sel] sampled at that edge.
- Continuous request with competitors present: gnt is held for exactly MAX_HOLD cycles. f_valid is high for MAX_HOLD cycles, shifted one edge later.
- With MAX_HOLD=1: strict per-cycle rotation among active requesters.
- Requester drop: release happens at the first edge where req[s] is seen low. f_valid goes 0 at that edge.
- Handoff edge: f_valid reflects the outgoing grantee.
- Simultaneous release and a new request: the new request participates in the decision at that edge.
- cnt never exceeds MAX_HOLD.

## Test plan
- **Reset mid-grant.** Setup: req=0001, rst pulsed high for 3 ns at cycle 2. Required: gnt, sel, f, f_valid read 0 while rst is high, without waiting for a clock edge. Then with req=0100 after rst falls: gnt=0100, sel=2 one edge later.
- **Single requester.** Stimulus: req=0001, d0=0xA5. Required:
  - gnt=0001 at edge 1.
  - f=0xA5 with f_valid=1 from edge 2.
  - After 10 cycles, gnt has never dropped.
  - After req=0: gnt=0 next edge, f stays 0xA5, f_valid=0.
- **Full contention from reset, MAX_HOLD=4.** Stimulus: req=1111. Required: gnt sequence 0001, 0010, 0100, 1000, 0001, each for 4 cycles, with no all-zero cycle between grants.
- **Early release with handoff.** Stimulus: req0 and req2 high, req0 granted, req0 drops after its 2nd grant cycle. Required: gnt 0001→0100 on the edge that sees req0 low. f_valid=0 for that one edge, then 1 with f=d2.
- **Wrap-around.** Stimulus: requester 2 granted and released, then req=0101. Required: next gnt=0001 (ptr=3 wraps to 0) rather than 0100.
- **All requests drop.** Stimulus: req→0000 during GRANT. Required: next edge gnt=0, state IDLE, f unchanged, f_valid=0. A re-request of the same index is granted 1 edge after it appears.
